// File: rtl/pg_pkg.sv
// Shared types and sizing helpers for the power-gating isolation sequencer.
package pg_pkg;

   typedef enum logic [2:0] {PG_ON, PG_ISO, PG_OFFW, PG_OFF, PG_WAKE, PG_REL} pg_state_t;

   // Counter must hold the largest dwell or timeout value it is ever loaded with.
   function automatic int pg_cnt_w(input int iso_setup, input int release_cyc, input int ack_timeout);
      int m;
      m = iso_setup;
      if (release_cyc > m) m = release_cyc;
      if (ack_timeout > m) m = ack_timeout;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pg_domain_fsm.sv
// One gated domain: clamp/switch sequencing FSM, shared dwell/timeout counter,
// hold register and the clamp mux on the domain's output lane.
module pg_domain_fsm
   import pg_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int ISO_SETUP   = 2,
   parameter int RELEASE_CYC = 4,
   parameter int ACK_TIMEOUT = 64,
   parameter int CLAMP_HOLD  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwrDownReq,
   input  logic             pwrSwitchAck,
   input  logic [WIDTH-1:0] signalIn,
   input  logic [WIDTH-1:0] clampValue,
   output logic [WIDTH-1:0] signalOut,
   output logic             clampEn,
   output logic             pwrSwitchEn,
   output logic             domainReady,
   output logic             ackErr
);

   localparam int CW = pg_cnt_w(ISO_SETUP, RELEASE_CYC, ACK_TIMEOUT);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t ISO_LD = cnt_t'(ISO_SETUP);
   localparam cnt_t REL_LD = cnt_t'(RELEASE_CYC);
   localparam cnt_t ACK_LD = cnt_t'(ACK_TIMEOUT);
   localparam cnt_t ONE    = cnt_t'(1);

   pg_state_t        state, state_nxt;
   cnt_t             cnt, cnt_nxt;
   logic             err_set;
   logic [WIDTH-1:0] hold_reg;

   // Counter values of 1 mean "this is the last cycle"; it is never decremented below 1,
   // so the count saturates instead of wrapping.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      case (state)
         PG_ON: begin
            if (pwrDownReq) begin
               state_nxt = PG_ISO;
               cnt_nxt   = ISO_LD;
            end
         end
         PG_ISO: begin
            if (!pwrDownReq) begin
               state_nxt = PG_REL;
               cnt_nxt   = REL_LD;
            end else if (cnt <= ONE) begin
               state_nxt = PG_OFFW;
               cnt_nxt   = ACK_LD;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         PG_OFFW: begin
            if (!pwrSwitchAck) begin
               state_nxt = PG_OFF;
            end else if (cnt <= ONE) begin
               state_nxt = PG_OFF;
               err_set   = 1'b1;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         PG_OFF: begin
            if (!pwrDownReq) begin
               state_nxt = PG_WAKE;
               cnt_nxt   = ACK_LD;
            end
         end
         PG_WAKE: begin
            if (pwrSwitchAck) begin
               state_nxt = PG_REL;
               cnt_nxt   = REL_LD;
            end else if (cnt <= ONE) begin
               state_nxt = PG_REL;
               cnt_nxt   = REL_LD;
               err_set   = 1'b1;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         PG_REL: begin
            if (cnt <= ONE) state_nxt = PG_ON;
            else            cnt_nxt   = cnt - ONE;
         end
         default: begin
            state_nxt = PG_REL;
            cnt_nxt   = REL_LD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= PG_REL;
         cnt         <= REL_LD;
         clampEn     <= 1'b1;
         pwrSwitchEn <= 1'b1;
         ackErr      <= 1'b0;
         hold_reg    <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         clampEn     <= (state_nxt != PG_ON);
         pwrSwitchEn <= !(state_nxt inside {PG_OFFW, PG_OFF});
         if (err_set)  ackErr   <= 1'b1;
         if (!clampEn) hold_reg <= signalIn;
      end
   end

   assign domainReady = (state == PG_ON);
   assign signalOut   = clampEn ? ((CLAMP_HOLD != 0) ? hold_reg : clampValue) : signalIn;

endmodule

// File: rtl/pg_isolation_seq.sv
// Multi-domain power-gating sequencer: one independent clamp/switch FSM per domain,
// buses sliced per lane.
module pg_isolation_seq
   import pg_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_DOM     = 4,
   parameter int ISO_SETUP   = 2,
   parameter int RELEASE_CYC = 4,
   parameter int ACK_TIMEOUT = 64,
   parameter int CLAMP_HOLD  = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_DOM-1:0]       pwrDownReq,
   input  logic [NUM_DOM-1:0]       pwrSwitchAck,
   input  logic [NUM_DOM*WIDTH-1:0] signalIn,
   input  logic [NUM_DOM*WIDTH-1:0] clampValue,
   output logic [NUM_DOM*WIDTH-1:0] signalOut,
   output logic [NUM_DOM-1:0]       clampEn,
   output logic [NUM_DOM-1:0]       pwrSwitchEn,
   output logic [NUM_DOM-1:0]       domainReady,
   output logic [NUM_DOM-1:0]       ackErr
);

   for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
      pg_domain_fsm #(
         .WIDTH       (WIDTH),
         .ISO_SETUP   (ISO_SETUP),
         .RELEASE_CYC (RELEASE_CYC),
         .ACK_TIMEOUT (ACK_TIMEOUT),
         .CLAMP_HOLD  (CLAMP_HOLD)
      ) u_dom (
         .clk          (clk),
         .reset_n      (reset_n),
         .pwrDownReq   (pwrDownReq[d]),
         .pwrSwitchAck (pwrSwitchAck[d]),
         .signalIn     (signalIn[d*WIDTH +: WIDTH]),
         .clampValue   (clampValue[d*WIDTH +: WIDTH]),
         .signalOut    (signalOut[d*WIDTH +: WIDTH]),
         .clampEn      (clampEn[d]),
         .pwrSwitchEn  (pwrSwitchEn[d]),
         .domainReady  (domainReady[d]),
         .ackErr       (ackErr[d])
      );
   end

endmodule

// File: tb/tb_pg_isolation_seq.sv
// Scoreboard bench: a phase/timestamp reference model predicts every cycle's outputs for a
// fixed-clamp instance and a hold-mode instance driven by the same stimulus.
module tb_pg_isolation_seq;

   localparam int W   = 32;
   localparam int ND  = 4;
   localparam int ISO = 2;
   localparam int REL = 4;
   localparam int TO  = 64;
   localparam int BW  = ND * W;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [ND-1:0] req = '0;
   logic [ND-1:0] ack = '1;
   logic [BW-1:0] sig = '0;
   logic [BW-1:0] cv  = '0;
   logic [BW-1:0] so0, so1;
   logic [ND-1:0] ce0, ce1, pe0, pe1, rd0, rd1, er0, er1;

   pg_isolation_seq #(.WIDTH(W), .NUM_DOM(ND), .ISO_SETUP(ISO), .RELEASE_CYC(REL),
                      .ACK_TIMEOUT(TO), .CLAMP_HOLD(0)) u_fix (
      .clk(clk), .reset_n(reset_n), .pwrDownReq(req), .pwrSwitchAck(ack),
      .signalIn(sig), .clampValue(cv), .signalOut(so0), .clampEn(ce0),
      .pwrSwitchEn(pe0), .domainReady(rd0), .ackErr(er0));

   pg_isolation_seq #(.WIDTH(W), .NUM_DOM(ND), .ISO_SETUP(ISO), .RELEASE_CYC(REL),
                      .ACK_TIMEOUT(TO), .CLAMP_HOLD(1)) u_hold (
      .clk(clk), .reset_n(reset_n), .pwrDownReq(req), .pwrSwitchAck(ack),
      .signalIn(sig), .clampValue(cv), .signalOut(so1), .clampEn(ce1),
      .pwrSwitchEn(pe1), .domainReady(rd1), .ackErr(er1));

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [ND-1:0] ce, pe, rd, er;
      logic [BW-1:0] so0, so1;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Model phases, in the order a domain walks through them.
   localparam int UP = 0, PRE = 1, SWOFF = 2, DOWN = 3, SWON = 4, SETTLE = 5;
   int            ph[ND];
   int            stamp[ND];
   int            cyc = 0;
   logic [ND-1:0] err_m = '0;
   logic [W-1:0]  hold_m[ND];
   exp_t          cur;
   int            stuck[ND];

   task automatic go(input int d, input int p);
      ph[d]    = p;
      stamp[d] = cyc;
   endtask

   // Advance the model across one rising edge using the inputs driven before it.
   task automatic tick();
      exp_t e;
      int   el;
      @(posedge clk);
      cyc++;
      for (int d = 0; d < ND; d++) begin
         if (!reset_n) begin
            go(d, SETTLE);
            err_m[d]  = 1'b0;
            hold_m[d] = '0;
         end else begin
            if (ph[d] == UP) hold_m[d] = sig[d*W +: W];
            el = cyc - stamp[d];
            case (ph[d])
               UP:     if (req[d]) go(d, PRE);
               PRE:    if (!req[d]) go(d, SETTLE); else if (el >= ISO) go(d, SWOFF);
               SWOFF:  if (!ack[d]) go(d, DOWN);
                       else if (el >= TO) begin err_m[d] = 1'b1; go(d, DOWN); end
               DOWN:   if (!req[d]) go(d, SWON);
               SWON:   if (ack[d]) go(d, SETTLE);
                       else if (el >= TO) begin err_m[d] = 1'b1; go(d, SETTLE); end
               default: if (el >= REL) go(d, UP);
            endcase
         end
      end
      for (int d = 0; d < ND; d++) begin
         e.ce[d] = (ph[d] != UP);
         e.pe[d] = !(ph[d] == SWOFF || ph[d] == DOWN);
         e.rd[d] = (ph[d] == UP);
         e.er[d] = err_m[d];
         e.so0[d*W +: W] = e.ce[d] ? cv[d*W +: W] : sig[d*W +: W];
         e.so1[d*W +: W] = e.ce[d] ? hold_m[d]    : sig[d*W +: W];
      end
      cur = e;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set, compared against the queue head.
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("clampEn",        BW'(ce0), BW'(e.ce));
         chk("pwrSwitchEn",    BW'(pe0), BW'(e.pe));
         chk("domainReady",    BW'(rd0), BW'(e.rd));
         chk("ackErr",         BW'(er0), BW'(e.er));
         chk("signalOut_fix",  so0, e.so0);
         chk("ctl_hold",       BW'({ce1, pe1, rd1, er1}), BW'({e.ce, e.pe, e.rd, e.er}));
         chk("signalOut_hold", so1, e.so1);
      end
   end

   // Unclamped lane must belong to a powered, ready domain.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int d = 0; d < ND; d++) begin
            total++;
            if (!ce0[d] && !(pe0[d] && rd0[d])) begin
               bad++;
               $display("FAIL invariant dom%0d: clampEn=0 pwrSwitchEn=%b domainReady=%b", d, pe0[d], rd0[d]);
            end
         end
      end
   end

   initial begin
      for (int d = 0; d < ND; d++) stuck[d] = 0;
      sig = {$urandom, $urandom, $urandom, $urandom};
      cv  = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (6) tick();

      cv[0 +: W] = 32'hDEAD_BEEF;
      req[0] = 1'b1;
      repeat (3) tick();
      ack[0] = 1'b0;
      repeat (3) tick();

      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      repeat (8) tick();

      req[0] = 1'b0;
      repeat (10) tick();
      ack[0] = 1'b1;
      repeat (8) tick();

      req[2] = 1'b1;
      repeat (72) tick();
      req[2] = 1'b0;
      repeat (8) tick();

      sig[3*W +: W] = 32'h0000_1234;
      tick();
      req[3] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sig[3*W +: W] = $urandom;
         if (i == 3) ack[3] = 1'b0;
         tick();
      end
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      ack[3]  = 1'b1;
      req[3]  = 1'b0;
      repeat (6) tick();

      // Random traffic: the rail follows the switch with random lag, occasionally sticks.
      for (int c = 0; c < 500; c++) begin
         for (int d = 0; d < ND; d++) begin
            if ($urandom_range(0, 15) == 0) req[d] = ~req[d];
            if ($urandom_range(0, 99) == 0) stuck[d] = 80;
            if (stuck[d] > 0) stuck[d]--;
            else if ($urandom_range(0, 3) == 0) ack[d] = cur.pe[d];
            else if ($urandom_range(0, 63) == 0) ack[d] = ~ack[d];
         end
         sig = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 7) == 0) cv = {$urandom, $urandom, $urandom, $urandom};
         if (c == 250) reset_n = 1'b0;
         if (c == 252) reset_n = 1'b1;
         tick();
      end

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
